// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and defaults for the FIR filter and its downstream blocks
package fir_pkg;
  localparam int FIR_OUT_W = 17;
  localparam int FIR_IN_W = 8;
  localparam int DEF_LOG2_DEC = 3;
  localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/fir_out_decimator_if.sv
// fir_out_decimator_if: sample input and decimated-result output handshake
interface fir_out_decimator_if
  import fir_pkg::*;
#(
  parameter int IN_W = FIR_OUT_W
);
  logic in_valid;
  logic [IN_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [IN_W-1:0] out_data;
  logic overflow;
  modport master (output in_valid, in_data, out_ready, input out_valid, out_data, overflow);
  modport slave (input in_valid, in_data, out_ready, output out_valid, out_data, overflow);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: result queue; pointers carry an extra wrap bit to tell full from empty
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic full,
  output logic empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = mem[rd_ptr[AW-1:0]];
  // advance pointers; a push into a full queue only lands when a pop frees the slot
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  // storage write
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: boxcar-averages 2^LOG2_DEC samples and queues results behind valid/ready
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int IN_W = FIR_OUT_W,
  parameter int LOG2_DEC = DEF_LOG2_DEC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic clock,
  input logic reset,
  fir_out_decimator_if.slave bus
);
  localparam int ACC_W = IN_W + LOG2_DEC;
  logic [ACC_W-1:0] acc, sum;
  logic [LOG2_DEC-1:0] cnt;
  logic last, push, pop_ok, full, empty, ovf;
  logic [IN_W-1:0] head;
  assign sum = acc + ACC_W'(bus.in_data);
  assign last = &cnt;
  assign push = bus.in_valid & last & ~reset;
  assign pop_ok = bus.out_ready & ~empty;
  // accumulate-and-dump; counter wraps naturally on the final sample
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.in_valid) begin
      acc <= last ? '0 : sum;
      cnt <= cnt + LOG2_DEC'(1);
    end
  end
  // sticky overrun: a result arrived at a full queue with no pop to make room
  always_ff @(posedge clock) begin
    if (reset) ovf <= 1'b0;
    else if (push & full & ~pop_ok) ovf <= 1'b1;
  end
  sync_fifo #(.WIDTH(IN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(bus.out_ready),
    .din(sum[ACC_W-1:LOG2_DEC]),
    .full(full),
    .empty(empty),
    .head(head)
  );
  assign bus.out_valid = ~empty;
  assign bus.out_data = empty ? '0 : head;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb_fir_out_decimator: directed vector table plus hand-written corner sequences
module tb_fir_out_decimator;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int failures = 0;
  fir_out_decimator_if #(.IN_W(17)) bus ();
  fir_out_decimator #(.IN_W(17), .LOG2_DEC(3), .FIFO_DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  typedef struct {
    logic v;
    logic [16:0] d;
    logic r;
    logic ev;
    logic [16:0] ed;
    logic eo;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic v, logic [16:0] d, logic r, logic ev, logic [16:0] ed, logic eo);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.ev = ev; x.ed = ed; x.eo = eo;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(logic v, logic [16:0] d, logic r);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    step(0, 0, 0);
    reset = 0;
  endtask

  task automatic frame(logic [16:0] val, logic r);
    for (int i = 0; i < 8; i++) step(1, val, r);
  endtask

  task automatic expect_out(string name, logic ev, logic [16:0] ed, logic eo);
    chk({name, "_valid"}, bus.out_valid, ev);
    chk({name, "_data"}, bus.out_data, ed);
    chk({name, "_ovf"}, bus.overflow, eo);
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    for (int i = 0; i < 7; i++) add(1, 1000, 1, 0, 0, 0);
    add(1, 1000, 1, 1, 1000, 0);
    add(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      add(1, 17'(i), 1, i == 7, (i == 7) ? 17'd3 : 17'd0, 0);
      if (i != 7) add(0, 17'd99, 1, 0, 0, 0);
    end
    add(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 17'd131071, 1, i == 7, (i == 7) ? 17'd131071 : 17'd0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 1, i == 7, 0, 0);
    add(0, 0, 1, 0, 0, 0);

    step(0, 0, 0);
    step(0, 0, 0);
    reset = 0;
    expect_out("reset", 0, 0, 0);

    foreach (vecs[k]) begin
      step(vecs[k].v, vecs[k].d, vecs[k].r);
      chk($sformatf("vec%0d_valid", k), bus.out_valid, vecs[k].ev);
      chk($sformatf("vec%0d_data", k), bus.out_data, vecs[k].ed);
      chk($sformatf("vec%0d_ovf", k), bus.overflow, vecs[k].eo);
    end

    do_reset();
    frame(10, 0); frame(20, 0); frame(30, 0); frame(40, 0); frame(50, 0);
    expect_out("ovf_full", 1, 10, 1);
    step(0, 0, 1);
    expect_out("ovf_pop1", 1, 20, 1);
    step(0, 0, 1);
    expect_out("ovf_pop2", 1, 30, 1);
    step(0, 0, 1);
    expect_out("ovf_pop3", 1, 40, 1);
    step(0, 0, 1);
    expect_out("ovf_drained", 0, 0, 1);

    for (int i = 0; i < 5; i++) step(1, 500, 0);
    do_reset();
    expect_out("midreset", 0, 0, 0);
    frame(16, 0);
    expect_out("midreset_res", 1, 16, 0);
    step(0, 0, 1);
    expect_out("midreset_single", 0, 0, 0);

    for (int i = 0; i < 7; i++) step(1, 700, 0);
    reset = 1;
    step(1, 700, 0);
    reset = 0;
    expect_out("reset_final", 0, 0, 0);
    frame(8, 0);
    expect_out("after_reset_final", 1, 8, 0);

    do_reset();
    frame(10, 0); frame(20, 0); frame(30, 0); frame(40, 0);
    for (int i = 0; i < 7; i++) step(1, 50, 0);
    step(1, 50, 1);
    expect_out("fullpop", 1, 20, 0);
    step(0, 0, 1);
    expect_out("fullpop_d30", 1, 30, 0);
    step(0, 0, 1);
    expect_out("fullpop_d40", 1, 40, 0);
    step(0, 0, 1);
    expect_out("fullpop_d50", 1, 50, 0);
    step(0, 0, 1);
    expect_out("fullpop_empty", 0, 0, 0);

    do_reset();
    frame(100, 0);
    expect_out("one_entry", 1, 100, 0);
    for (int i = 0; i < 7; i++) step(1, 200, 0);
    step(1, 200, 1);
    expect_out("pushpop_head", 1, 200, 0);
    step(0, 0, 1);
    expect_out("pushpop_occ1", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
